// File: rtl/render_bus_target.sv
// render_bus_target: memory-side endpoint of the renderer's multiplexed 8-bit bus.
// Serves scene RAM byte reads (RAM is loaded through the host port). Framebuffer
// writes (A[23]=1) are packed three bytes per 24-bit pixel and then streamed out
// through a small FIFO.
// Ports: clk/rst (sync, active high); bus_stb/bus_lo/bus_hi -> rd_data (bus side);
//        host_we/host_addr/host_wdata (scene RAM load);
//        pix_valid/pix_ready/pix_data/pix_index (pixel stream);
//        proto_err/ovf_err (sticky errors); frame_done (frame pulse).
// Optional: define FRAME_DONE_EN to enable the frame pixel counter and frame_done.
module render_bus_target #(
    parameter int RAM_AW       = 9,
    parameter int FIFO_DEPTH   = 4,
    parameter int FRAME_PIXELS = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_stb,
    input  logic [7:0]        bus_lo,
    input  logic [7:0]        bus_hi,
    output logic [7:0]        rd_data,
    input  logic              host_we,
    input  logic [RAM_AW-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [23:0]       pix_data,
    output logic [15:0]       pix_index,
    output logic              proto_err,
    output logic              ovf_err,
    output logic              frame_done
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HI,
        S_RWAIT,
        S_WDATA
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic        proto_set;
    logic        rd_load;
    logic        cap;

    logic [7:0]  ram_q [2**RAM_AW];
    logic [7:0]  rd_data_q;
    logic        in_range;

    logic [1:0]  lane_q;
    logic [7:0]  b0_q, b1_q;
    logic [15:0] seq_q;
    logic        push;

    logic [39:0] mem_q [FIFO_DEPTH];
    logic [PW:0] wp_q, rp_q;
    logic        empty, full, pop, push_ok, drop;
    logic [39:0] head;
    logic        proto_q, ovf_q;

    // ---------------- phase FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        proto_set = 1'b0;
        rd_load   = 1'b0;
        cap       = 1'b0;
        if (bus_stb) begin
            // A strobe always starts a new transaction; mid-transaction it
            // abandons the current one and flags the protocol violation.
            addr_d[15:0] = {bus_hi, bus_lo};
            state_d      = S_HI;
            proto_set    = (state_q != S_IDLE);
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_HI: begin
                    addr_d[23:16] = bus_lo;
                    if (bus_hi == 8'h00) begin
                        state_d = S_RWAIT;
                    end else if (bus_hi == 8'hFF) begin
                        state_d = S_WDATA;
                    end else begin
                        proto_set = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                S_RWAIT: begin
                    rd_load = 1'b1;
                    state_d = S_IDLE;
                end
                S_WDATA: begin
                    // Writes below the framebuffer region are silently ignored.
                    cap     = addr_q[23];
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- scene RAM ----------------
    assign in_range = (addr_q[23:RAM_AW] == '0);

    // Non-blocking write: a same-cycle read of this address sees the old byte.
    always_ff @(posedge clk) begin
        if (host_we) ram_q[host_addr] <= host_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= 8'h00;
        end else if (rd_load) begin
            rd_data_q <= in_range ? ram_q[addr_q[RAM_AW-1:0]] : 8'h00;
        end
    end

    assign rd_data = rd_data_q;

    // ---------------- pixel assembly ----------------
    assign push = cap && (lane_q == 2'd2);

    // Lane returns to 0 on every push, which also covers the frame wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= 2'd0;
            b0_q   <= 8'h00;
            b1_q   <= 8'h00;
            seq_q  <= 16'd0;
        end else if (cap) begin
            unique case (1'b1)
                lane_q == 2'd0: begin
                    b0_q   <= bus_lo;
                    lane_q <= 2'd1;
                end
                lane_q == 2'd1: begin
                    b1_q   <= bus_lo;
                    lane_q <= 2'd2;
                end
                default: begin
                    lane_q <= 2'd0;
                    seq_q  <= seq_q + 16'd1;
                end
            endcase
        end
    end

    // ---------------- pixel FIFO ----------------
    assign empty   = (wp_q == rp_q);
    assign full    = (wp_q[PW] != rp_q[PW]) &&
                     (wp_q[PW-1:0] == rp_q[PW-1:0]);
    assign pop     = !empty && pix_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wp_q[PW-1:0]] <= {seq_q, bus_lo, b1_q, b0_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            proto_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok)   wp_q    <= wp_q + 1'b1;
            if (pop)       rp_q    <= rp_q + 1'b1;
            if (proto_set) proto_q <= 1'b1;
            if (drop)      ovf_q   <= 1'b1;
        end
    end

    // Head entry is gated so the stream reads as zero while empty.
    assign head      = mem_q[rp_q[PW-1:0]];
    assign pix_valid = !empty;
    assign pix_data  = empty ? 24'h0 : head[23:0];
    assign pix_index = empty ? 16'h0 : head[39:24];
    assign proto_err = proto_q;
    assign ovf_err   = ovf_q;

    // ---------------- frame counter ----------------
`ifdef FRAME_DONE_EN
    localparam int FW = $clog2(FRAME_PIXELS + 1);

    logic [FW-1:0] frm_q;
    logic          frm_wrap;

    // Counts push attempts, so dropped pixels still advance the frame.
    assign frm_wrap = push && (frm_q == FW'(FRAME_PIXELS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            frm_q <= '0;
        end else if (push) begin
            frm_q <= frm_wrap ? '0 : frm_q + 1'b1;
        end
    end

    assign frame_done = frm_wrap;
`else
    logic unused_frame;
    assign unused_frame = (FRAME_PIXELS == 0);
    assign frame_done   = 1'b0;
`endif

endmodule

// File: doc/render_bus_target.md
Name: render_bus_target

Overview:
- Memory-side endpoint of the renderer's multiplexed 8-bit external bus.
- Serves scene/shape-list byte reads from an internal RAM loaded by a host port.
- Captures the renderer's framebuffer writes (region 0x800000 and up) and assembles each three-byte write group into a 24-bit pixel.
- Pushes pixels into a small FIFO and emits them on a valid/ready stream toward display/scanout logic.

Parameters:
- RAM_AW, 9: scene RAM address width; depth 2^RAM_AW bytes.
- FIFO_DEPTH, 4: pixel FIFO entries; power of two, ≥2.
- FRAME_PIXELS, 16384: pixels per frame (128x128); used only with FRAME_DONE_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active high.
- bus_stb  in  1  high in the address-low phase (T0) of every transaction.
- bus_lo  in  8  renderer uo_out.
- bus_hi  in  8  renderer uio_out.
- rd_data  out  8  read data, driven to renderer ui_in.
- host_we  in  1  scene RAM write strobe.
- host_addr  in  RAM_AW  scene RAM write address.
- host_wdata  in  8  scene RAM write data.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  consumer accepts pixel.
- pix_data  out  24  {byte2, byte1, byte0}, i.e. colour[23:0].
- pix_index  out  16  sequence number of pix_data.
- proto_err  out  1  sticky: malformed transaction.
- ovf_err  out  1  sticky: pixel dropped because the FIFO was full.
- frame_done  out  1  one-cycle pulse (FRAME_DONE_EN only; otherwise tied 0).

Behaviour:
- Reset (rst=1 at a clock edge): every output is 0. FIFO is emptied, byte lane = 0, pixel sequence counter = 0, phase FSM = IDLE. Scene RAM contents are not cleared.
- Phase FSM states: IDLE, HI, RWAIT, WDATA.
  - IDLE→HI when bus_stb=1: latch A[7:0]=bus_lo, A[15:8]=bus_hi.
  - In HI: latch A[23:16]=bus_lo.
    - bus_hi=0x00: read, go to RWAIT.
    - bus_hi=0xFF: write, go to WDATA.
    - Any other value: set proto_err, go to IDLE.
  - RWAIT→IDLE: register RAM[A[RAM_AW-1:0]] into rd_data. The value is therefore valid in cycle T3 and held until the next read updates it.
    - If A[23:RAM_AW]≠0, rd_data←0x00.
  - WDATA→IDLE: capture bus_lo as a data byte only if A[23]=1. Writes with A[23]=0 are ignored and raise no error.
  - bus_stb=1 while in HI, RWAIT or WDATA: set proto_err, abandon the current transaction, start the new one (go to HI with the new address latched).
- Pixel assembly:
  - Captured byte goes to lane 0, 1, 2 in turn (lane 0 = pix_data[7:0]). Lane wraps 2→0.
  - When lane 2 completes, push the 24-bit pixel tagged with the sequence counter, then increment the counter. The counter wraps at 0xFFFF→0.
  - Write-address contiguity is not checked.
- FIFO and stream:
  - pix_valid = FIFO not empty. pix_data/pix_index come from the head entry, registered; they are stable while pix_valid=1 and pix_ready=0.
  - Pop on pix_valid & pix_ready.
  - Push into a full FIFO: pixel dropped, ovf_err set, sequence counter still increments so the consumer sees the gap.
  - Push and pop in the same cycle when full: both succeed, no drop.
  - Latency: pixel visible on pix_valid the cycle after the lane-2 WDATA cycle, when the FIFO was empty.
- Host port:
  - host_we writes RAM[host_addr] at the edge.
  - Host write and RWAIT read of the same address in the same cycle: the read returns the old byte.
- Sticky errors clear only on rst.

Optional Feature:
- Macro FRAME_DONE_EN.
- Defined: a pixel counter increments on every push attempt (accepted or dropped). When it reaches FRAME_PIXELS-1 and increments, frame_done pulses high for one cycle concurrent with that push. The counter then returns to 0, and the byte lane is forced to 0.
- Not defined: frame_done is constant 0 and no counter exists.

Test Plan:
- Host writes RAM[0x000]=0x03; bus read of address 0x000000 (stb, then hi=0x00) → rd_data=0x03 in T3; a read of 0x001000 → rd_data=0x00.
- Three writes to 0x800000..0x800002 with data 0x11, 0x22, 0x33, pix_ready=1 → one pixel: pix_data=0x332211, pix_index=0, pix_valid high for one cycle.
- pix_ready=0, 5 pixels written with FIFO_DEPTH=4 → pixels 0..3 retained, ovf_err=1. Then pix_ready=1 → indices 0, 1, 2, 3 emerge; the next written pixel carries index 5.
- HI phase with bus_hi=0x5A → proto_err=1, no byte captured. bus_stb asserted during RWAIT → proto_err=1 and the new transaction completes normally.
- rst asserted between lane 1 and lane 2 → all outputs 0. The next three writes 0xAA, 0xBB, 0xCC yield pix_data=0xCCBBAA, pix_index=0.
- FRAME_DONE_EN with FRAME_PIXELS=4: 4 pixels written → frame_done pulses exactly once, with the 4th push; the 5th pixel produces no pulse.
